// File: rtl/bomberman_input_pkg.sv
// Shared types and helpers for the per-player input sequencer.
package bomberman_input_pkg;

    localparam int unsigned DIR_W = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } chan_state_t;

    // Fixed priority pick over {right, left, down, up}; up wins.
    function automatic dir_t pick_dir(input logic [DIR_W-1:0] keys);
        dir_t d;
        d = DIR_RIGHT;
        if (keys[0])      d = DIR_UP;
        else if (keys[1]) d = DIR_DOWN;
        else if (keys[2]) d = DIR_LEFT;
        return d;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/player_input_channel.sv
// One player's direction FSM with initial-delay/auto-repeat, bomb cooldown and key edge registers.
module player_input_channel
    import bomberman_input_pkg::*;
#(
    parameter int unsigned INITIAL_DELAY = 8,
    parameter int unsigned MOVE_PERIOD   = 4,
    parameter int unsigned BOMB_COOLDOWN = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic [DIR_W-1:0] key_dir,
    input  logic             key_bomb,
    output logic             xmov,
    output logic             xdir,
    output logic             ymov,
    output logic             ydir,
    output logic             move_stb,
    output logic             bomb_stb
);

    localparam int unsigned CW = cnt_width(INITIAL_DELAY, MOVE_PERIOD, BOMB_COOLDOWN);
    localparam logic [CW-1:0] LOAD_FIRST  = CW'(INITIAL_DELAY);
    localparam logic [CW-1:0] LOAD_REPEAT = CW'(MOVE_PERIOD);
    localparam logic [CW-1:0] LOAD_COOL   = CW'(BOMB_COOLDOWN);

    chan_state_t      state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cool_q, cool_d;
    logic [DIR_W-1:0] key_q, key_d;
    logic             bomb_key_q, bomb_key_d;
    logic             en_q, en_d;
    logic             xmov_q, xmov_d, xdir_q, xdir_d;
    logic             ymov_q, ymov_d, ydir_q, ydir_d;
    logic             move_stb_q, move_stb_d;
    logic             bomb_stb_q, bomb_stb_d;

    logic [DIR_W-1:0] key_rise;
    logic             new_valid;
    dir_t             new_dir;

    // Next-state: new direction beats expiry; full release idles silently.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        cool_d     = cool_q;
        move_stb_d = 1'b0;
        bomb_stb_d = 1'b0;
        key_d      = key_dir;
        bomb_key_d = key_bomb;
        en_d       = enable;
        new_valid  = 1'b0;
        new_dir    = dir_q;
        xmov_d     = 1'b0;
        xdir_d     = 1'b0;
        ymov_d     = 1'b0;
        ydir_d     = 1'b0;
        key_rise   = key_dir & ~key_q;

        if (enable) begin
            if (!en_q && (|key_dir)) begin
                new_valid = 1'b1;
                new_dir   = pick_dir(key_dir);
            end else if (|key_rise) begin
                new_valid = 1'b1;
                new_dir   = pick_dir(key_rise);
            end else if ((state_q != IDLE) && !key_dir[dir_q] && (|key_dir)) begin
                new_valid = 1'b1;
                new_dir   = pick_dir(key_dir);
            end
        end

        if (!enable || (key_dir == '0)) begin
            state_d = IDLE;
        end else if (new_valid) begin
            state_d    = FIRST;
            dir_d      = new_dir;
            cnt_d      = LOAD_FIRST;
            move_stb_d = 1'b1;
        end else if ((state_q != IDLE) && frame_tick) begin
            if (cnt_q <= CW'(1)) begin
                state_d    = REPEAT;
                cnt_d      = LOAD_REPEAT;
                move_stb_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        if (enable && key_bomb && !bomb_key_q && (cool_q == '0)) begin
            bomb_stb_d = 1'b1;
            cool_d     = LOAD_COOL;
        end else if (frame_tick && (cool_q != '0)) begin
            cool_d = cool_q - CW'(1);
        end

        if (state_d != IDLE) begin
            case (dir_d)
                DIR_UP:    ymov_d = 1'b1;
                DIR_DOWN:  begin ymov_d = 1'b1; ydir_d = 1'b1; end
                DIR_LEFT:  xmov_d = 1'b1;
                DIR_RIGHT: begin xmov_d = 1'b1; xdir_d = 1'b1; end
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_UP;
            cnt_q      <= '0;
            cool_q     <= '0;
            key_q      <= '0;
            bomb_key_q <= 1'b0;
            en_q       <= 1'b0;
            xmov_q     <= 1'b0;
            xdir_q     <= 1'b0;
            ymov_q     <= 1'b0;
            ydir_q     <= 1'b0;
            move_stb_q <= 1'b0;
            bomb_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            cool_q     <= cool_d;
            key_q      <= key_d;
            bomb_key_q <= bomb_key_d;
            en_q       <= en_d;
            xmov_q     <= xmov_d;
            xdir_q     <= xdir_d;
            ymov_q     <= ymov_d;
            ydir_q     <= ydir_d;
            move_stb_q <= move_stb_d;
            bomb_stb_q <= bomb_stb_d;
        end
    end

    assign xmov     = xmov_q;
    assign xdir     = xdir_q;
    assign ymov     = ymov_q;
    assign ydir     = ydir_q;
    assign move_stb = move_stb_q;
    assign bomb_stb = bomb_stb_q;

endmodule

// File: rtl/player_input_sequencer.sv
// Per-player input sequencer: one channel per player plus the shared start-key edge strobe.
module player_input_sequencer
    import bomberman_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned INITIAL_DELAY = 8,
    parameter int unsigned MOVE_PERIOD   = 4,
    parameter int unsigned BOMB_COOLDOWN = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   enable,
    input  logic [NUM_PLAYERS-1:0] key_up,
    input  logic [NUM_PLAYERS-1:0] key_down,
    input  logic [NUM_PLAYERS-1:0] key_left,
    input  logic [NUM_PLAYERS-1:0] key_right,
    input  logic [NUM_PLAYERS-1:0] key_bomb,
    input  logic                   key_start,
    output logic [NUM_PLAYERS-1:0] xmov,
    output logic [NUM_PLAYERS-1:0] xdir,
    output logic [NUM_PLAYERS-1:0] ymov,
    output logic [NUM_PLAYERS-1:0] ydir,
    output logic [NUM_PLAYERS-1:0] move_stb,
    output logic [NUM_PLAYERS-1:0] bomb_stb,
    output logic                   start_stb
);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
        logic [DIR_W-1:0] key_dir;
        assign key_dir = {key_right[p], key_left[p], key_down[p], key_up[p]};

        player_input_channel #(
            .INITIAL_DELAY (INITIAL_DELAY),
            .MOVE_PERIOD   (MOVE_PERIOD),
            .BOMB_COOLDOWN (BOMB_COOLDOWN)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .frame_tick (frame_tick),
            .enable     (enable),
            .key_dir    (key_dir),
            .key_bomb   (key_bomb[p]),
            .xmov       (xmov[p]),
            .xdir       (xdir[p]),
            .ymov       (ymov[p]),
            .ydir       (ydir[p]),
            .move_stb   (move_stb[p]),
            .bomb_stb   (bomb_stb[p])
        );
    end

    // Start is deliberately not gated by enable.
    logic start_key_q, start_key_d;
    logic start_stb_q, start_stb_d;

    always_comb begin
        start_key_d = key_start;
        start_stb_d = key_start & ~start_key_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_key_q <= 1'b0;
            start_stb_q <= 1'b0;
        end else begin
            start_key_q <= start_key_d;
            start_stb_q <= start_stb_d;
        end
    end

    assign start_stb = start_stb_q;

endmodule
